// File: rtl/scan_doubler_if.sv
// Video bus between the ULA-facing side and the scan doubler.
//   pixelEnable : 7 MHz pixel qualifier
//   rgbIn       : ULA pixel {rrr,ggg,bbb}
//   hSyncIn     : ULA hsync, active low
//   vSyncIn     : ULA vsync, active low
//   rgbOut      : doubled-rate pixel
//   hSyncOut    : doubled-rate hsync, active low
//   vSyncOut    : vsync, one clock delayed, active low
// master = video source / sink side, slave = scan doubler.
interface scan_doubler_if;
  logic       pixelEnable;
  logic [8:0] rgbIn;
  logic       hSyncIn;
  logic       vSyncIn;
  logic [8:0] rgbOut;
  logic       hSyncOut;
  logic       vSyncOut;

  modport master (
    output pixelEnable, rgbIn, hSyncIn, vSyncIn,
    input  rgbOut, hSyncOut, vSyncOut
  );

  modport slave (
    input  pixelEnable, rgbIn, hSyncIn, vSyncIn,
    output rgbOut, hSyncOut, vSyncOut
  );
endinterface

// File: rtl/scan_doubler.sv
// Scan doubler: 15.6 kHz / 7 MHz-pixel ULA video in, 31.2 kHz video out.
// Each input line is captured into one half of a ping-pong line buffer while
// the other half (previous line) is replayed twice at the full clock rate.
// Ports:
//   clock : 14 MHz system clock
//   reset : asynchronous, active-low
//   vid   : video bus (slave modport), see scan_doubler_if
module scan_doubler #(
  parameter int LINE_LEN = 456,
  parameter int HS_START = 344,
  parameter int HS_WIDTH = 32,
  parameter int AW       = 9
) (
  input  logic          clock,
  input  logic          reset,
  scan_doubler_if.slave vid
);

  localparam logic [AW-1:0] LAST  = AW'(LINE_LEN - 1);
  localparam logic [AW-1:0] HS_LO = AW'(HS_START);
  localparam logic [AW-1:0] HS_HI = AW'(HS_START + HS_WIDTH - 1);

  // Two banks of 2^AW entries; bank select is the address MSB.
  logic [8:0]    lineMem [0:(2**(AW+1))-1];

  logic [AW-1:0] wrCount;
  logic [AW-1:0] rdCount;
  logic          wrBank;
  logic          valid;
  logic          hsPrev;
  logic          lineStart;
  logic          hsWin;
  logic [AW:0]   wrAddr;
  logic [AW:0]   rdAddr;

  // hsync falling edge, sampled only on pixel-rate cycles
  assign lineStart = vid.pixelEnable & hsPrev & ~vid.hSyncIn;
  assign hsWin     = (rdCount >= HS_LO) && (rdCount <= HS_HI);

  // On lineStart the write already targets the bank about to become current,
  // while this cycle's read still uses the old read bank; the two halves never
  // coincide except on that one cycle, where read-old-data semantics apply.
  assign wrAddr = lineStart ? {~wrBank, {AW{1'b0}}} : {wrBank, wrCount};
  assign rdAddr = {~wrBank, rdCount};

  // Buffer RAM is intentionally left unreset.
  always_ff @(posedge clock) begin
    if (vid.pixelEnable) lineMem[wrAddr] <= vid.rgbIn;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrCount      <= '0;
      rdCount      <= '0;
      wrBank       <= 1'b0;
      valid        <= 1'b0;
      hsPrev       <= 1'b1;
      vid.rgbOut   <= '0;
      vid.hSyncOut <= 1'b1;
      vid.vSyncOut <= 1'b1;
    end else begin
      // write side
      if (vid.pixelEnable) begin
        hsPrev <= vid.hSyncIn;
        if (lineStart) begin
          wrBank  <= ~wrBank;
          wrCount <= '0;
          valid   <= 1'b1;
        end else if (wrCount < LAST) begin
          wrCount <= wrCount + 1'b1;
        end
        // at LAST the count saturates; further pixels keep overwriting LAST
      end

      // read side: restart on a new line, otherwise wrap at line end
      if (lineStart || rdCount == LAST) rdCount <= '0;
      else                               rdCount <= rdCount + 1'b1;

      // output stage
      vid.rgbOut   <= (!valid || hsWin) ? 9'd0 : lineMem[rdAddr];
      vid.hSyncOut <= ~hsWin;
      vid.vSyncOut <= vid.vSyncIn;
    end
  end

endmodule

// File: tb/tb_scan_doubler.sv
// Bench for scan_doubler: random pixels and line timings, checked every cycle
// against a line-level reference model (line capture by pixel ordinal, output
// phase from time elapsed since the last detected line start).
module tb_scan_doubler;
  localparam int L   = 456;
  localparam int HSS = 344;
  localparam int HSW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  scan_doubler_if vid();

  scan_doubler #(.LINE_LEN(L), .HS_START(HSS), .HS_WIDTH(HSW), .AW(9)) dut (
    .clock (clock),
    .reset (reset),
    .vid   (vid)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Two line stores; capture goes to one, replay comes from the other.
  logic [8:0] mm [2][512];
  bit         kn [2][512];
  int         e = 0;        // index of the next clock edge
  int         base = 0;     // edge at which the output phase was last 0
  int         ord;          // pixel ordinal since the last line start
  bit         capBank, started, hsPrevM;
  logic [8:0] expRgb;
  logic       expHs, expVs;
  bit         expKnown;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      capBank = 0; started = 0; hsPrevM = 1; ord = 1; base = e;
      expRgb = 0; expHs = 1; expVs = 1; expKnown = 1;
    end else begin : mdl
      int ph, a;
      bit inHs, ls;
      ph   = (e - base) % L;
      inHs = (ph >= HSS) && (ph <= HSS + HSW - 1);
      if (!started || inHs) begin
        expRgb = 0; expKnown = 1;
      end else begin
        expRgb = mm[!capBank][ph]; expKnown = kn[!capBank][ph];
      end
      expHs = !inHs;
      expVs = vid.vSyncIn;
      if (vid.pixelEnable) begin
        ls = hsPrevM && !vid.hSyncIn;
        if (ls) begin
          capBank = !capBank; ord = 0; started = 1; base = e + 1;
        end
        // the line-start pixel and the one after it share slot 0
        a = (ord == 0) ? 0 : ((ord - 1 > L - 1) ? L - 1 : ord - 1);
        mm[capBank][a] = vid.rgbIn;
        kn[capBank][a] = 1;
        if (ord < 1000000) ord++;
        hsPrevM = vid.hSyncIn;
      end
      e++;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (expKnown) chk("rgbOut", 32'(vid.rgbOut), 32'(expRgb));
      chk("hSyncOut", 32'(vid.hSyncOut), 32'(expHs));
      chk("vSyncOut", 32'(vid.vSyncOut), 32'(expVs));
    end
  end

  // ---------------- stimulus ----------------
  // Every task starts and ends on a falling edge.
  task automatic pix(input logic [8:0] v, input bit hs, input bit vs, input int gap);
    vid.pixelEnable = 1'b1; vid.rgbIn = v; vid.hSyncIn = hs; vid.vSyncIn = vs;
    @(negedge clock);
    repeat (gap) begin
      vid.pixelEnable = 1'b0;
      @(negedge clock);
    end
  endtask

  // mode 0: every other clock, 1: every clock, 2: random gaps
  task automatic sendLine(input int n, input int nPix, input int hsAt, input bit vs,
                          input int mode, input bit pat);
    for (int k = 0; k < nPix; k++) begin
      logic [8:0] v;
      bit hs;
      int gap;
      v   = pat ? 9'((n * 8 + k) & 32'h1FF) : 9'($urandom);
      hs  = !(hsAt >= 0 && k >= hsAt && k < hsAt + HSW);
      gap = (mode == 0) ? 1 : (mode == 1) ? 0 : int'($urandom_range(2, 0));
      pix(v, hs, vs, gap);
    end
  endtask

  task automatic waitPhase(input int ph);
    int g = 0;
    while (((e - base) % L) != ph && g < 2 * L) begin
      vid.pixelEnable = 1'b0;
      @(negedge clock);
      g++;
    end
    if (g >= 2 * L) chk("waitBudget", 32'(g), 32'(2 * L - 1));
  endtask

  initial begin
    vid.pixelEnable = 1'b0; vid.rgbIn = '0; vid.hSyncIn = 1'b1; vid.vSyncIn = 1'b1;
    repeat (3) @(negedge clock);
    chk("rstRgb", 32'(vid.rgbOut), 32'd0);
    chk("rstHs",  32'(vid.hSyncOut), 32'd1);
    chk("rstVs",  32'(vid.vSyncOut), 32'd1);
    reset = 1'b1;

    // patterned lines at nominal timing
    for (int n = 0; n < 4; n++) sendLine(n, L, HSS, 1'b1, 0, 1'b1);

    // long line with no hsync: capture saturates at the last slot
    sendLine(0, 600, -1, 1'b1, 0, 1'b0);
    for (int n = 0; n < 3; n++) sendLine(n, L, HSS, 1'b1, 0, 1'b0);

    // missing hsync: last complete line keeps repeating
    sendLine(0, L, -1, 1'b1, 0, 1'b0);
    sendLine(0, L, HSS, 1'b1, 0, 1'b0);

    // truncation: line start lands at output phase 200
    sendLine(0, 50, -1, 1'b1, 0, 1'b0);
    waitPhase(200);
    for (int k = 0; k < HSW; k++) pix(9'($urandom), 1'b0, 1'b1, 1);
    sendLine(0, 300, -1, 1'b1, 0, 1'b0);
    sendLine(0, L, HSS, 1'b1, 0, 1'b0);

    // vsync low for four input lines
    for (int n = 0; n < 4; n++) sendLine(n, L, HSS, 1'b0, 0, 1'b0);
    for (int n = 0; n < 2; n++) sendLine(n, L, HSS, 1'b1, 0, 1'b0);

    // pixelEnable held high, then random pixel cadence and short lines
    sendLine(0, L, HSS, 1'b1, 1, 1'b0);
    sendLine(0, L, 100, 1'b1, 1, 1'b0);
    for (int n = 0; n < 3; n++) sendLine(n, 200 + int'($urandom_range(300, 0)), 150, 1'b1, 2, 1'b0);
    sendLine(0, L, HSS, 1'b1, 0, 1'b0);

    // asynchronous reset in the middle of an output line
    waitPhase(100);
    vid.pixelEnable = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midRstRgb", 32'(vid.rgbOut), 32'd0);
    chk("midRstHs",  32'(vid.hSyncOut), 32'd1);
    chk("midRstVs",  32'(vid.vSyncOut), 32'd1);
    @(negedge clock);
    vid.vSyncIn = 1'b0;
    repeat (3) @(negedge clock);
    vid.vSyncIn = 1'b1;
    reset = 1'b1;
    // black until the first hsync edge after release
    sendLine(0, 300, -1, 1'b1, 0, 1'b0);
    for (int n = 0; n < 3; n++) sendLine(n, L, HSS, 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
